// File: rtl/prog_mem_loadable_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem_loadable_pkg
//  Description : Shared definitions for the loadable instruction memory:
//                loader FSM state encoding, bytes-per-word helper and the
//                NOP encoding used to fill unused memory words.
//  Revision    : 1.0  initial release
// ============================================================================
package prog_mem_loadable_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // NOP is the all-zero word; one bit replicated to the instruction width
    localparam logic C_NOP_BIT = 1'b0;

    // Number of load bytes making up one instruction word (BPW)
    function automatic int unsigned bytes_per_word(input int unsigned ir_width);
        return ir_width / 8;
    endfunction

endpackage : prog_mem_loadable_pkg
`default_nettype wire

// File: rtl/prog_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : prog_word_assembler
//  Description : Collects load bytes (most-significant first) into one
//                instruction word. Flags the byte that completes a word; a
//                last byte arriving mid-word completes it early, with the
//                missing low bytes zero-padded.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                i_clear         restart assembly (start of a new load)
//                i_valid         i_data accepted this cycle
//                i_data          load byte
//                i_last          final byte of the program
//                o_word          assembled (padded) word, valid with
//                                o_word_complete
//                o_word_complete word finished this cycle
//                o_padded        word finished early and was zero-padded
//  Revision    : 1.0  initial release
// ============================================================================
module prog_word_assembler
    import prog_mem_loadable_pkg::*;
#(
    parameter int unsigned IR_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_valid,
    input  logic [7:0]          i_data,
    input  logic                i_last,
    output logic [IR_WIDTH-1:0] o_word,
    output logic                o_word_complete,
    output logic                o_padded
);

    localparam int unsigned BPW   = bytes_per_word(IR_WIDTH);
    localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(BPW - 1);

    logic [IR_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic [IR_WIDTH-1:0] w_next;
    logic [CNT_W-1:0]    w_pad_bytes;
    logic                w_full;

    // Bytes already held sit in the low end; the new byte is appended below.
    assign w_next      = (r_shift << 8) | IR_WIDTH'(i_data);
    assign w_full      = (r_cnt == C_LAST_IDX);
    // On an early last byte, move the partial word up so the padding
    // lands in the low-order bytes. A full word needs no shift.
    assign w_pad_bytes = C_LAST_IDX - r_cnt;
    assign o_word      = w_next << {w_pad_bytes, 3'b000};

    assign o_word_complete = i_valid && (w_full || i_last);
    assign o_padded        = i_valid && i_last && !w_full;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            if (o_word_complete) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else begin
                r_shift <= w_next;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

endmodule : prog_word_assembler
`default_nettype wire

// File: rtl/prog_mem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem_loadable
//  Description : Run-time loadable instruction memory. Registered fetch port
//                (pc -> ir) plus a byte-wide load port that writes the
//                program from address 0, zero-fills the unused tail and
//                reports word count, checksum and error flags.
//  Ports       : clk, res              clock / synchronous active-high reset
//                pc, ir, ir_valid,     fetch address, registered instruction,
//                pc_fault              result qualifier, out-of-range flag
//                load_start            begin a load (honoured only when idle)
//                ld_data/valid/last,   load byte stream, MS byte first;
//                ld_ready              accepted when ld_valid && ld_ready
//                busy, load_done       core stall, one-cycle end-of-load pulse
//                load_count, checksum, words written, mod-256 byte sum,
//                load_err, overflow    partial last word, too many words
//  Revision    : 1.0  initial release
// ============================================================================
module prog_mem_loadable
    import prog_mem_loadable_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 8,
    parameter int unsigned IR_WIDTH = 16,
    parameter int unsigned DEPTH    = 64
) (
    input  logic                clk,
    input  logic                res,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [IR_WIDTH-1:0] ir,
    output logic                ir_valid,
    output logic                pc_fault,
    input  logic                load_start,
    input  logic [7:0]          ld_data,
    input  logic                ld_valid,
    input  logic                ld_last,
    output logic                ld_ready,
    output logic                busy,
    output logic                load_done,
    output logic [PC_WIDTH:0]   load_count,
    output logic [7:0]          checksum,
    output logic                load_err,
    output logic                overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PC_WIDTH:0] C_DEPTH     = (PC_WIDTH + 1)'(DEPTH);
    localparam logic [PC_WIDTH:0] C_LAST_ADDR = (PC_WIDTH + 1)'(DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IR_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PC_WIDTH:0]   r_addr;
    logic [PC_WIDTH:0]   r_load_count;
    logic [7:0]          r_checksum;
    logic                r_load_err;
    logic                r_overflow;
    logic [IR_WIDTH-1:0] r_ir;
    logic                r_ir_valid;
    logic                r_pc_fault;

    logic                w_busy;
    logic                w_ld_ready;
    logic                w_load_done;
    logic                w_accept;
    logic                w_start;
    logic                w_addr_in_range;
    logic [PC_WIDTH:0]   w_addr_inc;
    logic [IR_WIDTH-1:0] w_word;
    logic                w_word_complete;
    logic                w_padded;
    logic                w_we;
    logic [AW-1:0]       w_waddr;
    logic [IR_WIDTH-1:0] w_wdata;

    assign w_accept        = (r_state == ST_LOAD) && ld_valid;
    assign w_start         = (r_state == ST_IDLE) && load_start;
    assign w_addr_in_range = (r_addr < C_DEPTH);
    // Write address saturates at DEPTH so further words are recognised as overflow
    assign w_addr_inc      = w_addr_in_range ? (r_addr + 1'b1) : r_addr;

    prog_word_assembler #(
        .IR_WIDTH (IR_WIDTH)
    ) u_asm (
        .clk             (clk),
        .rst             (res),
        .i_clear         (w_start),
        .i_valid         (w_accept),
        .i_data          (ld_data),
        .i_last          (ld_last),
        .o_word          (w_word),
        .o_word_complete (w_word_complete),
        .o_padded        (w_padded)
    );

    // ---------------- loader FSM ----------------
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_ld_ready  = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ld_ready = 1'b1;
                // A last byte always completes a word, so w_addr_inc is the
                // first address left unwritten by the program.
                if (w_accept && ld_last) begin
                    w_state_nxt = (w_addr_inc < C_DEPTH) ? ST_CLEAR : ST_DONE;
                end
            end
            ST_CLEAR: begin
                if (r_addr >= C_LAST_ADDR) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_load_done = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- load bookkeeping ----------------
    always_ff @(posedge clk) begin
        if (res || w_start) begin
            r_addr       <= '0;
            r_load_count <= '0;
            r_checksum   <= '0;
            r_load_err   <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            if (w_accept) begin
                r_checksum <= r_checksum + ld_data;
                if (w_word_complete) begin
                    r_addr <= w_addr_inc;
                    if (r_load_count < C_DEPTH) begin
                        r_load_count <= r_load_count + 1'b1;
                    end
                    if (!w_addr_in_range) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_padded) begin
                        r_load_err <= 1'b1;
                    end
                end
            end
        end else if (r_state == ST_CLEAR) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // ---------------- storage ----------------
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_addr[AW-1:0];
        w_wdata = w_word;
        if (!res) begin
            if ((r_state == ST_LOAD) && w_word_complete && w_addr_in_range) begin
                w_we = 1'b1;
            end else if (r_state == ST_CLEAR) begin
                w_we    = 1'b1;
                w_wdata = {IR_WIDTH{C_NOP_BIT}};
            end
        end
    end

    // Array is deliberately not reset; contents come from a completed load.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // ---------------- fetch register ----------------
    always_ff @(posedge clk) begin
        if (res || w_busy) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_pc_fault <= 1'b0;
        end else if ({1'b0, pc} >= C_DEPTH) begin
            r_ir       <= {IR_WIDTH{C_NOP_BIT}};
            r_ir_valid <= 1'b1;
            r_pc_fault <= 1'b1;
        end else begin
            r_ir       <= r_mem[pc[AW-1:0]];
            r_ir_valid <= 1'b1;
            r_pc_fault <= 1'b0;
        end
    end

    assign ir         = r_ir;
    assign ir_valid   = r_ir_valid;
    assign pc_fault   = r_pc_fault;
    assign ld_ready   = w_ld_ready;
    assign busy       = w_busy;
    assign load_done  = w_load_done;
    assign load_count = r_load_count;
    assign checksum   = r_checksum;
    assign load_err   = r_load_err;
    assign overflow   = r_overflow;

endmodule : prog_mem_loadable
`default_nettype wire
